// File: rtl/vec_load_gather.sv
// Strided vector load: fetches 1/4/16 words at base+i*stride and packs them into one RF write; latency N+2 from start at full rate.
// Backpressure: requests hold address/valid until mem_req_ready; in-flight reads capped at MAX_OUT, responses accepted unconditionally.
module vec_load_gather #(
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [1:0]        vl,
  input  logic [4:0]        vd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              rf_we,
  output logic [1:0]        rf_vl,
  output logic [4:0]        rf_wa,
  output logic [511:0]      rf_wd
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  localparam logic [4:0] MAX_OUT_C = 5'(MAX_OUT);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, stride_q;
  logic [1:0]        vl_q;
  logic [4:0]        vd_q;
  logic [4:0]        req_cnt, rsp_cnt, n_elem, inflight;
  logic [511:0]      data_q;
  logic              rej_q;
  logic              start_ok, cmd_ok, req_fire, rsp_fire;

  function automatic logic [4:0] elems(input logic [1:0] code);
    case (code)
      2'b00:   return 5'd1;
      2'b01:   return 5'd4;
      default: return 5'd16;
    endcase
  endfunction

  // Element count only meaningful for legal codes; illegal ones are rejected before use.
  assign cmd_ok   = (vl != 2'b11) && (({1'b0, vd} + {1'b0, elems(vl)}) <= 6'd32);
  assign start_ok = (state == IDLE) && start;
  assign n_elem   = elems(vl_q);
  assign inflight = req_cnt - rsp_cnt;

  assign mem_req_valid = (state == FETCH) && (req_cnt < n_elem) && (inflight < MAX_OUT_C);
  assign mem_req_addr  = addr_q;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_fire      = (state == FETCH) && mem_rsp_valid && (rsp_cnt < n_elem);

  assign rf_wd = data_q;
  assign rf_wa = vd_q;
  assign rf_vl = vl_q;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    rf_we     = 1'b0;
    done      = rej_q;
    err       = rej_q;
    case (state)
      IDLE: begin
        if (start && cmd_ok) state_nxt = FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (rsp_fire && (rsp_cnt + 5'd1 == n_elem)) state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        rf_we     = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      vl_q     <= '0;
      vd_q     <= '0;
      req_cnt  <= '0;
      rsp_cnt  <= '0;
      data_q   <= '0;
      rej_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      rej_q <= start_ok && !cmd_ok;
      if (start_ok) begin
        addr_q   <= base;
        stride_q <= stride;
        vl_q     <= vl;
        vd_q     <= vd;
        req_cnt  <= '0;
        rsp_cnt  <= '0;
        data_q   <= '0;
      end else begin
        // Running address replaces base + req_cnt*stride; wraps naturally at ADDR_W.
        if (req_fire) begin
          req_cnt <= req_cnt + 5'd1;
          addr_q  <= addr_q + stride_q;
        end
        if (rsp_fire) begin
          data_q[{rsp_cnt[3:0], 5'b0} +: 32] <= mem_rsp_data;
          rsp_cnt <= rsp_cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_load_gather.sv
// Directed bench for vec_load_gather with an in-order, fixed-latency memory model.
module tb_vec_load_gather;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [31:0]  base, stride;
  logic [1:0]   vl;
  logic [4:0]   vd;
  logic         busy, done, err, mem_req_valid;
  logic         mem_req_ready = 1'b1;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid = 1'b0;
  logic [31:0]  mem_rsp_data = 32'h0;
  logic         rf_we;
  logic [1:0]   rf_vl;
  logic [4:0]   rf_wa;
  logic [511:0] rf_wd;

  vec_load_gather #(.ADDR_W(32), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .stride(stride),
    .vl(vl), .vd(vd), .busy(busy), .done(done), .err(err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .rf_we(rf_we), .rf_vl(rf_vl),
    .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t         rq[$];
  int           cyc = 0;
  int           lat = 1;
  bit           rdy_rand = 1'b0;
  logic [31:0]  key = 32'h0;
  int           hs = 0, rs = 0, max_out = 0;
  int           we_cnt = 0, done_cnt = 0, req_seen = 0, stall_bad = 0;
  int           we_cyc = 0, done_cyc = 0;
  logic [511:0] cap_wd = '0;
  logic [4:0]   cap_wa = '0;
  logic [1:0]   cap_vl = '0;
  logic         cap_err = 1'b0;
  logic         pstall = 1'b0;
  logic [31:0]  paddr = '0;
  int           t0, we0, rs0, dc0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and monitor: data returned is address ^ key, lat cycles after the handshake.
  always @(negedge clk) begin
    if (pstall && busy && (!mem_req_valid || mem_req_addr != paddr)) stall_bad++;
    mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mem_req_valid) req_seen++;
    if (mem_req_valid && mem_req_ready) begin
      rq.push_back('{cyc + lat, mem_req_addr ^ key});
      hs++;
    end
    pstall = mem_req_valid && !mem_req_ready;
    paddr  = mem_req_addr;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rq[0].data;
      rq.delete(0);
      rs++;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0BAD0BAD;
    end
    if (hs - rs > max_out) max_out = hs - rs;
    if (rf_we) begin
      we_cnt++;
      we_cyc = cyc;
      cap_wd = rf_wd;
      cap_wa = rf_wa;
      cap_vl = rf_vl;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      cap_err  = err;
    end
  end

  task automatic run(input logic [1:0] v, input logic [4:0] d, input logic [31:0] b,
                     input logic [31:0] s, input bit poke);
    int i;
    i = 0;
    @(posedge clk);
    we0 = we_cnt; rs0 = req_seen; dc0 = done_cnt;
    @(negedge clk);
    vl = v; vd = d; base = b; stride = s; start = 1'b1; t0 = cyc;
    do begin
      @(negedge clk);
      start = poke && (i == 3 || i == 9);
      if (start) begin
        vl = 2'b00; vd = 5'd31; base = 32'hFFF0;
      end
      i++;
    end while (!done && i < 400);
    start = 1'b0;
    chk("no_timeout", done, 1'b1);
    @(posedge clk);
  endtask

  initial begin
    logic [511:0] exp, ref_wd;
    rst = 1'b1; start = 1'b0; base = '0; stride = '0; vl = '0; vd = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, done, err, mem_req_valid, rf_we}, 5'b0);
    chk("rst_wd", rf_wd, '0);
    chk("rst_regs", {rf_wa, rf_vl, mem_req_addr}, '0);
    rst = 1'b0;

    // Single element: address 0x100 ^ key = 0xDEADBEEF
    key = 32'hDEADBFEF;
    run(2'b00, 5'd5, 32'h100, 32'h4, 1'b0);
    chk("t1_wd", cap_wd, {480'h0, 32'hDEADBEEF});
    chk("t1_wa", cap_wa, 5'd5);
    chk("t1_vl", cap_vl, 2'b00);
    chk("t1_err", cap_err, 1'b0);
    chk("t1_we_cnt", we_cnt - we0, 1);
    chk("t1_reqs", req_seen - rs0, 1);
    chk("t1_lat", we_cyc - t0, 3);
    chk("t1_done_with_we", done_cyc - we_cyc, 0);
    @(negedge clk);
    chk("t1_hold", {rf_wa, rf_wd}, {5'd5, 480'h0, 32'hDEADBEEF});
    chk("t1_idle", {busy, rf_we, done}, 3'b0);

    // Negative stride, four elements
    key = 32'h0;
    run(2'b01, 5'd28, 32'h200, 32'hFFFFFFFC, 1'b0);
    chk("t2_wd", cap_wd, {384'h0, 32'h1F4, 32'h1F8, 32'h1FC, 32'h200});
    chk("t2_wa", cap_wa, 5'd28);
    chk("t2_vl", cap_vl, 2'b01);
    chk("t2_lat", we_cyc - t0, 6);
    chk("t2_reqs", req_seen - rs0, 4);

    // Sixteen elements, 5-cycle memory: outstanding must cap at 4
    lat = 5;
    max_out = 0;
    run(2'b10, 5'd16, 32'h400, 32'h4, 1'b0);
    exp = '0;
    for (int i = 0; i < 16; i++) exp[32*i +: 32] = 32'h400 + 32'(4 * i);
    chk("t3_wd", cap_wd, exp);
    chk("t3_max_out", max_out, 4);
    chk("t3_wa", cap_wa, 5'd16);
    chk("t3_we_cnt", we_cnt - we0, 1);
    chk("t3_reqs", req_seen - rs0, 16);

    // Illegal codes are rejected after one cycle with no traffic
    lat = 1;
    run(2'b11, 5'd0, 32'h0, 32'h4, 1'b0);
    chk("t4a_err", cap_err, 1'b1);
    chk("t4a_lat", done_cyc - t0, 1);
    chk("t4a_traffic", {32'(we_cnt - we0), 32'(req_seen - rs0)}, 64'h0);
    run(2'b10, 5'd17, 32'h0, 32'h4, 1'b0);
    chk("t4b_err", cap_err, 1'b1);
    chk("t4b_lat", done_cyc - t0, 1);
    chk("t4b_traffic", {32'(we_cnt - we0), 32'(req_seen - rs0)}, 64'h0);
    run(2'b00, 5'd31, 32'h40, 32'h0, 1'b0);
    chk("t4c_ok", {cap_err, cap_wa}, {1'b0, 5'd31});
    chk("t4c_wd", cap_wd, {480'h0, 32'h40});

    // Stalled ready and stray starts must not change the result
    lat = 2;
    run(2'b10, 5'd0, 32'h1000, 32'h8, 1'b0);
    ref_wd = cap_wd;
    exp = '0;
    for (int i = 0; i < 16; i++) exp[32*i +: 32] = 32'h1000 + 32'(8 * i);
    chk("t5_ref", ref_wd, exp);
    stall_bad = 0;
    rdy_rand = 1'b1;
    run(2'b10, 5'd0, 32'h1000, 32'h8, 1'b1);
    rdy_rand = 1'b0;
    chk("t5_same", cap_wd, ref_wd);
    chk("t5_wa_vl", {cap_wa, cap_vl}, {5'd0, 2'b10});
    chk("t5_stable", stall_bad, 0);
    chk("t5_we_cnt", we_cnt - we0, 1);

    // Reset in the middle of a fetch; stale responses must be dropped
    lat = 5;
    @(posedge clk);
    we0 = we_cnt; dc0 = done_cnt;
    @(negedge clk);
    vl = 2'b10; vd = 5'd16; base = 32'h800; stride = 32'h4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ctl", {busy, done, err, mem_req_valid, rf_we}, 5'b0);
    chk("t6_wd", rf_wd, '0);
    chk("t6_regs", {rf_wa, rf_vl, mem_req_addr}, '0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    chk("t6_no_we", we_cnt - we0, 0);
    chk("t6_no_done", done_cnt - dc0, 0);
    @(negedge clk);
    chk("t6_stale", rf_wd, '0);
    lat = 1;
    run(2'b00, 5'd3, 32'h300, 32'h0, 1'b0);
    chk("t6_wd_after", cap_wd, {480'h0, 32'h300});
    chk("t6_wa_after", cap_wa, 5'd3);
    chk("t6_lat_after", we_cyc - t0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 100000");
    $fatal(1);
  end

endmodule

// File: doc/vec_load_gather.md
Name: vec_load_gather

Overview:
- Vector load front-end that sits directly upstream of the 32x32-bit vector register file write port.
- On a start command it fetches 1, 4 or 16 32-bit words from data memory at base plus signed word stride, and packs them into a 512-bit write bundle.
- It then issues a single one-cycle register-file write (we/wa/VL/wd) that lands the words in consecutive registers starting at the destination register.

Parameters:
- ADDR_W, 32, byte-address width of the memory request port.
- MAX_OUT, 4, maximum outstanding (issued but not responded) memory reads; range 1..16.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  command strobe, accepted only when busy=0
- base  input  ADDR_W  byte address of element 0, word aligned
- stride  input  ADDR_W  signed byte stride between elements, word aligned
- vl  input  2  element count code: 00=1, 01=4, 10=16, 11=illegal
- vd  input  5  destination register index
- busy  output  1  command in progress
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle error pulse, coincident with done
- mem_req_valid  output  1  read request valid
- mem_req_ready  input  1  memory accepts request when high together with valid
- mem_req_addr  output  ADDR_W  read address
- mem_rsp_valid  input  1  read data valid, responses return in request order
- mem_rsp_data  input  32  read data
- rf_we  output  1  register-file write enable, one-cycle pulse
- rf_vl  output  2  VL code forwarded to register file
- rf_wa  output  5  destination base register
- rf_wd  output  512  packed data, element i in bits [32*i+31:32*i]

Behaviour:
- Reset: busy, done, err, mem_req_valid and rf_we are 0; rf_wd, rf_wa, rf_vl, mem_req_addr and all counters are 0; state is IDLE. Reset mid-command abandons it with no rf_we. Responses arriving after reset are ignored until the next start.
- The single clock is clk; reset is synchronous and active-high (rst).
- N = 1/4/16 for vl = 00/01/10.
- FSM states: IDLE, FETCH, WRITE.
- IDLE + start: base, stride, vl and vd are latched, and req_cnt, rsp_cnt and the data buffer are cleared.
  - If vl=11 or vd+N>32 (6-bit compare), the command is rejected: done=err=1 in the next cycle, no memory traffic, no rf_we, remain IDLE.
  - Otherwise the block goes to FETCH and busy=1 from the next cycle.
- start while busy=1 is ignored.
- FETCH:
  - mem_req_valid=1 while req_cnt<N and (req_cnt-rsp_cnt)<MAX_OUT.
  - mem_req_addr = base + req_cnt*stride, modulo 2^ADDR_W (wraps silently).
  - Address and valid are stable until the handshake; req_cnt increments on valid&ready.
  - Each mem_rsp_valid writes mem_rsp_data into lane rsp_cnt, then rsp_cnt increments.
  - A request and a response in the same cycle are both counted.
  - mem_rsp_valid while rsp_cnt==N, or in IDLE/WRITE, is ignored.
  - When rsp_cnt reaches N, the next state is WRITE.
- First mem_req_valid is asserted the cycle after start.
- WRITE (exactly one cycle): rf_we=1, rf_wa=vd, rf_vl=vl, rf_wd=buffer; done=1, err=0; busy=0 next cycle, return to IDLE.
- Lanes >= N of rf_wd are zero.
- rf_wd, rf_wa and rf_vl hold their values after the pulse until the next accepted command.
- Minimum latency with ready=1 and 1-cycle response: start at T, last response at T+N+1, rf_we/done at T+N+2.
- A new start is accepted in the same cycle done pulses only if busy=0 (i.e. not in WRITE); in WRITE it is ignored.

Test Plan:
- vl=00, vd=5, base=0x100, mem returns 0xDEADBEEF -> one request to addr 0x100; rf_we one cycle with rf_wa=5, rf_vl=00, rf_wd[31:0]=0xDEADBEEF, upper bits 0; done=1, err=0.
- vl=01, vd=28, base=0x200, stride=-4, data=addr -> addresses 0x200,0x1FC,0x1F8,0x1F4; lanes 0..3 hold the same values; rf_we at T+6 with ready=1 and 1-cycle latency.
- vl=10, vd=16, stride=4, MAX_OUT=4, memory latency 5 cycles -> never more than 4 outstanding; 16 lanes correct and in order; single rf_we.
- Illegal cases vl=11, or vl=10 with vd=17 -> done=err=1 one cycle after start; no mem_req_valid, no rf_we.
- mem_req_ready toggling 0/1 randomly plus start pulsed while busy -> address held stable while stalled; extra start ignored; result identical to the no-stall run.
- rst asserted during FETCH of a vl=10 command -> all outputs 0 next cycle; stale responses ignored; following vl=00 command completes correctly.
